// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes, data-memory waits with timeout fault.
// Define PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_stall_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned ZERO_REG    = 31,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             id_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             front_en,
    output logic             back_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FAULT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu_hz;
    logic              mem_stall;

    always_comb begin
        lu_hz = ex_mem_read && ex_reg_write && (ex_rd != REG_W'(ZERO_REG)) &&
                ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
        // A dropped mem_req in MEM_WAIT retires the wait just like mem_ready.
        mem_stall = mem_req && !mem_ready;
    end

    always_comb begin
        front_en    = 1'b1;
        back_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            front_en    = 1'b0;
            back_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state == FAULT || mem_stall) begin
            front_en = 1'b0;
            back_en  = 1'b0;
        end else if (lu_hz) begin
            front_en    = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_br_taken) begin
            ifid_flush = 1'b1;
        end
        mem_fault = (state == FAULT) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            state <= FAULT;
                        end
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= RUN;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!front_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ifid_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`else
    always_comb begin
        stall_cycles = '0;
        flush_count  = '0;
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_hazard_stall_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned ZREG  = 31;
    localparam int unsigned TMO   = 4;
    localparam int unsigned CW    = 3;
    localparam int          CMAX  = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rn, id_rm, ex_rd;
    logic             id_uses_rn, id_uses_rm, ex_mem_read, ex_reg_write;
    logic             id_br_taken, mem_req, mem_ready;
    logic             front_en, back_en, ifid_flush, idex_bubble, mem_fault;
    logic [CW-1:0]    stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;

    hazard_stall_ctrl #(
        .REG_W(REG_W), .ZERO_REG(ZREG), .MEM_TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .id_br_taken(id_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .front_en(front_en), .back_en(back_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mem_fault(mem_fault),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model state: are we waiting on memory, how many not-ready wait cycles elapsed, faulted?
    bit m_waiting = 0;
    int m_waited  = 0;
    bit m_faulted = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    function automatic bit reads_pending_load();
        if (!(ex_mem_read && ex_reg_write)) return 0;
        if (ex_rd == REG_W'(ZREG)) return 0;
        return (id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd);
    endfunction

    always @(negedge clk) begin
        bit e_fe, e_be, e_fl, e_bb, e_mf, mem_blocked;
        int e_sc, e_fc;
        mem_blocked = mem_req && !mem_ready;
        e_fe = 1; e_be = 1; e_fl = 0; e_bb = 0; e_mf = 0;
        if (reset) begin
            e_fe = 0; e_be = 0; e_fl = 1; e_bb = 1;
        end else if (m_faulted) begin
            e_fe = 0; e_be = 0; e_mf = 1;
        end else if (mem_blocked) begin
            e_fe = 0; e_be = 0;
        end else if (reads_pending_load()) begin
            e_fe = 0; e_bb = 1;
        end else if (id_br_taken) begin
            e_fl = 1;
        end
`ifdef PERF_CNT_EN
        e_sc = m_stalls;
        e_fc = m_flushes;
`else
        e_sc = 0;
        e_fc = 0;
`endif
        chk("model.front_en", int'(front_en), int'(e_fe));
        chk("model.back_en", int'(back_en), int'(e_be));
        chk("model.ifid_flush", int'(ifid_flush), int'(e_fl));
        chk("model.idex_bubble", int'(idex_bubble), int'(e_bb));
        chk("model.mem_fault", int'(mem_fault), int'(e_mf));
        chk("model.stall_cycles", int'(stall_cycles), e_sc);
        chk("model.flush_count", int'(flush_count), e_fc);
        if (reset) begin
            m_waiting = 0; m_waited = 0; m_faulted = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (!e_fe && m_stalls < CMAX) m_stalls++;
            if (e_fl && m_flushes < CMAX) m_flushes++;
            if (!m_faulted) begin
                if (mem_blocked) begin
                    if (m_waiting) begin
                        m_waited++;
                        if (m_waited == TMO) m_faulted = 1;
                    end
                    m_waiting = 1;
                end else begin
                    m_waiting = 0;
                    m_waited  = 0;
                end
            end
        end
    end

    task automatic idle();
        id_rn = '0; id_rm = '0; ex_rd = '0;
        id_uses_rn = 0; id_uses_rm = 0; ex_mem_read = 0; ex_reg_write = 0;
        id_br_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_rn(input logic [REG_W-1:0] r);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = r; id_rn = r; id_uses_rn = 1;
    endtask

    task automatic chk_en(input string name, input logic fe, input logic be, input logic fl, input logic bb);
        chk({name, ".front_en"}, int'(front_en), int'(fe));
        chk({name, ".back_en"}, int'(back_en), int'(be));
        chk({name, ".ifid_flush"}, int'(ifid_flush), int'(fl));
        chk({name, ".idex_bubble"}, int'(idex_bubble), int'(bb));
    endtask

    initial begin
        idle();
        reset = 1;
        go(); @(negedge clk);
        chk_en("reset", 0, 0, 1, 1);
        chk("reset.mem_fault", int'(mem_fault), 0);
        chk("reset.stall_cycles", int'(stall_cycles), 0);

        go(); reset = 0; @(negedge clk);
        chk_en("idle", 1, 1, 0, 0);

        go(); load_use_rn(5'd1); @(negedge clk);
        chk_en("lu_rn", 0, 1, 0, 1);
        go(); ex_mem_read = 0; @(negedge clk);
        chk_en("lu_clear", 1, 1, 0, 0);

        go(); load_use_rn(5'd31); @(negedge clk);
        chk_en("lu_xzr", 1, 1, 0, 0);

        go(); idle(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd7; id_rm = 5'd7; id_uses_rm = 1;
        @(negedge clk);
        chk_en("lu_rm", 0, 1, 0, 1);
        go(); id_uses_rm = 0; @(negedge clk);
        chk_en("lu_rm_unused", 1, 1, 0, 0);
        go(); id_uses_rm = 1; ex_reg_write = 0; @(negedge clk);
        chk_en("lu_nowrite", 1, 1, 0, 0);

        go(); idle(); id_br_taken = 1; @(negedge clk);
        chk_en("branch", 1, 1, 1, 0);
        go(); load_use_rn(5'd3); @(negedge clk);
        chk_en("branch_lu", 0, 1, 0, 1);

        // Memory wait: not ready cycles 0-3, ready in cycle 4 (the last legal cycle for TMO=4).
        go(); idle(); reset = 1;
        go(); reset = 0;
        for (int i = 0; i < 5; i++) begin
            mem_req = 1; mem_ready = (i == 4);
            @(negedge clk);
            if (i < 4) chk_en("memwait", 0, 0, 0, 0);
            else       chk_en("memdone", 1, 1, 0, 0);
            chk("memwait.mem_fault", int'(mem_fault), 0);
            go();
        end
        idle();
        @(negedge clk);
`ifdef PERF_CNT_EN
        chk("memwait.stall_cycles", int'(stall_cycles), 4);
`else
        chk("memwait.stall_cycles", int'(stall_cycles), 0);
`endif

        go(); mem_req = 1; mem_ready = 0;
        go(); mem_ready = 1; id_br_taken = 1; @(negedge clk);
        chk_en("memready_branch", 1, 1, 1, 0);
        go(); idle(); mem_req = 1;
        go(); mem_req = 0; @(negedge clk);
        chk_en("memreq_drop", 1, 1, 0, 0);

        // Timeout: never ready, fault entered at end of cycle 4.
        go(); idle(); reset = 1;
        go(); reset = 0; mem_req = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin mem_req = 0; id_br_taken = 1; end
            @(negedge clk);
            chk("timeout.mem_fault", int'(mem_fault), (i >= 5) ? 1 : 0);
            chk_en("timeout", 0, 0, 0, 0);
            if (i < 9) go();
        end
`ifdef PERF_CNT_EN
        chk("timeout.stall_sat", int'(stall_cycles), CMAX);
`else
        chk("timeout.stall_sat", int'(stall_cycles), 0);
`endif

        go(); idle(); reset = 1; @(negedge clk);
        chk("fault_reset.mem_fault", int'(mem_fault), 0);
        go(); reset = 0; @(negedge clk);
        chk_en("after_fault", 1, 1, 0, 0);
        chk("after_fault.mem_fault", int'(mem_fault), 0);
        chk("after_fault.stall_cycles", int'(stall_cycles), 0);

        go(); mem_req = 1;
        go();
        go(); reset = 1;
        go(); reset = 0; mem_req = 0; @(negedge clk);
        chk_en("wait_reset", 1, 1, 0, 0);

        // Mixed traffic, checked by the model each cycle.
        for (int i = 0; i < 300; i++) begin
            go();
            reset        = (i % 60 == 0);
            id_rn        = (($urandom_range(0, 7)) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            id_rm        = 5'($urandom_range(0, 3));
            ex_rd        = (($urandom_range(0, 7)) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            id_uses_rn   = 1'($urandom_range(0, 1));
            id_uses_rm   = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_reg_write = 1'($urandom_range(0, 1));
            id_br_taken  = ($urandom_range(0, 3) == 0);
            mem_req      = ($urandom_range(0, 2) == 0);
            mem_ready    = ($urandom_range(0, 3) == 0);
        end
        go(); idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
